// File: rtl/downstream_vc_receiver_if.sv
// Shared types and link/switch-side bundle for the downstream VC receiver.
//
// downstream_vc_receiver_pkg
//   VC_NUM, VC_W, PAYLOAD_W : network-wide sizing
//   flit_label_t            : HEAD / BODY / TAIL / HEADTAIL
//   flit_t                  : {flit_label, vc_id, payload}
//   vc_state_t              : per-VC packet state (IDLE / ACTIVE / DRAIN)
//
// downstream_vc_receiver_if ports
//   data_i, valid_flit_i         : flit from the upstream router
//   on_off_o, is_allocatable_o   : per-VC flow control back to upstream
//   rd_en_i, rd_vc_i             : pop request from the local switch stage
//   flit_o, flit_valid_o         : popped flit, one cycle after the pop
//   vc_empty_o                   : per-VC FIFO-empty flags
//
// Flow control: there is no per-flit ready. A flit presented with
// valid_flit_i=1 is consumed that cycle unconditionally. Upstream must stop
// sending on VC v while on_off_o[v]=0; the reserved slots absorb flits that
// were already in flight when on_off_o dropped. The read side is likewise
// fire-and-forget: rd_en_i pops if the VC holds a flit, and flit_valid_o
// marks the flit that pop produced.
// The master modport is the side that drives flits and pops (upstream
// router plus switch stage); the slave modport is the receiver.

package downstream_vc_receiver_pkg;
   localparam int VC_NUM    = 2;
   localparam int VC_W      = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int PAYLOAD_W = 16;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_label_t;

   typedef struct packed {
      flit_label_t          flit_label;
      logic [VC_W-1:0]      vc_id;
      logic [PAYLOAD_W-1:0] payload;
   } flit_t;

   typedef enum logic [1:0] {
      VC_IDLE   = 2'd0,
      VC_ACTIVE = 2'd1,
      VC_DRAIN  = 2'd2
   } vc_state_t;
endpackage

interface downstream_vc_receiver_if;
   import downstream_vc_receiver_pkg::*;

   flit_t             data_i;
   logic              valid_flit_i;
   logic [VC_NUM-1:0] on_off_o;
   logic [VC_NUM-1:0] is_allocatable_o;
   logic              rd_en_i;
   logic [VC_W-1:0]   rd_vc_i;
   flit_t             flit_o;
   logic              flit_valid_o;
   logic [VC_NUM-1:0] vc_empty_o;

   modport master (
      output data_i, valid_flit_i, rd_en_i, rd_vc_i,
      input  on_off_o, is_allocatable_o, flit_o, flit_valid_o, vc_empty_o
   );

   modport slave (
      input  data_i, valid_flit_i, rd_en_i, rd_vc_i,
      output on_off_o, is_allocatable_o, flit_o, flit_valid_o, vc_empty_o
   );
endinterface

// File: rtl/downstream_vc_receiver.sv
// Downstream end of a router-to-router link. Incoming flits are stored in a
// per-VC circular FIFO chosen by vc_id; a per-VC packet FSM polices flit
// labels; on/off flow control and VC allocatability go back upstream; the
// local switch stage pops flits through a VC-indexed read port.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   link            : downstream_vc_receiver_if.slave (flit in, flow control
//                     out, pop in, popped flit out, per-VC empty flags)
//   overflow_err_o  : sticky, a flit arrived at a full VC and was dropped
//   proto_err_o     : sticky, a flit label was illegal for its VC state
//   vc_state_o      : per-VC FSM state, for observation

module downstream_vc_receiver
   import downstream_vc_receiver_pkg::*;
#(
   parameter int BUFFER_SIZE = 8,
   parameter int OFF_MARGIN  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   downstream_vc_receiver_if.slave link,
   output logic                    overflow_err_o,
   output logic                    proto_err_o,
   output vc_state_t [VC_NUM-1:0]  vc_state_o
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int OCC_W = $clog2(BUFFER_SIZE + 1);

   flit_t            mem      [VC_NUM][BUFFER_SIZE];
   logic [PTR_W-1:0] wr_ptr   [VC_NUM];
   logic [PTR_W-1:0] rd_ptr   [VC_NUM];
   logic [OCC_W-1:0] occ      [VC_NUM];
   logic [OCC_W-1:0] occ_next [VC_NUM];
   vc_state_t        state      [VC_NUM];
   vc_state_t        state_next [VC_NUM];

   logic [VC_NUM-1:0] wr_req, legal, wr_en, rd_hit;
   logic [VC_NUM-1:0] full_drop, proto_drop;
   logic [VC_NUM-1:0] on_off_q, on_off_next;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         // Pops only see flits stored before this cycle: no write bypass.
         rd_hit[v] = link.rd_en_i && (link.rd_vc_i == VC_W'(v)) && (occ[v] != '0);
         wr_req[v] = link.valid_flit_i && (link.data_i.vc_id == VC_W'(v));

         case (state[v])
            VC_IDLE:   legal[v] = (link.data_i.flit_label == HEAD) ||
                                  (link.data_i.flit_label == HEADTAIL);
            VC_ACTIVE: legal[v] = (link.data_i.flit_label == BODY) ||
                                  (link.data_i.flit_label == TAIL);
            default:   legal[v] = 1'b0;
         endcase

         // A pop in the same cycle frees the slot, so a full VC still accepts.
         full_drop[v]  = wr_req[v] && (occ[v] == OCC_W'(BUFFER_SIZE)) && !rd_hit[v];
         proto_drop[v] = wr_req[v] && !legal[v];
         wr_en[v]      = wr_req[v] && !full_drop[v] && !proto_drop[v];

         occ_next[v]    = occ[v] + OCC_W'(wr_en[v]) - OCC_W'(rd_hit[v]);
         on_off_next[v] = !((BUFFER_SIZE - int'(occ_next[v])) <= OFF_MARGIN);

         // Writes are only legal in IDLE/ACTIVE and tail pops only happen in
         // DRAIN, so the two transition sources never collide.
         state_next[v] = state[v];
         if (wr_en[v]) begin
            case (state[v])
               VC_IDLE:   state_next[v] = (link.data_i.flit_label == HEAD) ? VC_ACTIVE : VC_DRAIN;
               VC_ACTIVE: state_next[v] = (link.data_i.flit_label == TAIL) ? VC_DRAIN : VC_ACTIVE;
               default:   state_next[v] = state[v];
            endcase
         end else if (rd_hit[v] && (state[v] == VC_DRAIN) &&
                      ((mem[v][rd_ptr[v]].flit_label == TAIL) ||
                       (mem[v][rd_ptr[v]].flit_label == HEADTAIL))) begin
            state_next[v] = VC_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (rst) state[v] <= VC_IDLE;
         else     state[v] <= state_next[v];
      end
   end

   // Storage is not reset; pointers and occupancy define what is valid.
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (wr_en[v]) mem[v][wr_ptr[v]] <= link.data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            wr_ptr[v] <= '0;
            rd_ptr[v] <= '0;
            occ[v]    <= '0;
         end
         on_off_q       <= '1;
         link.flit_o    <= '0;
         link.flit_valid_o <= 1'b0;
         overflow_err_o <= 1'b0;
         proto_err_o    <= 1'b0;
      end else begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (wr_en[v])  wr_ptr[v] <= ptr_inc(wr_ptr[v]);
            if (rd_hit[v]) rd_ptr[v] <= ptr_inc(rd_ptr[v]);
            occ[v] <= occ_next[v];
         end
         on_off_q          <= on_off_next;
         link.flit_valid_o <= |rd_hit;
         if (|rd_hit) link.flit_o <= mem[link.rd_vc_i][rd_ptr[link.rd_vc_i]];
         if (|full_drop)  overflow_err_o <= 1'b1;
         if (|proto_drop) proto_err_o    <= 1'b1;
      end
   end

   always_comb begin
      link.on_off_o = on_off_q;
      for (int v = 0; v < VC_NUM; v++) begin
         link.is_allocatable_o[v] = (state[v] == VC_IDLE);
         link.vc_empty_o[v]       = (occ[v] == '0);
         vc_state_o[v]            = state[v];
      end
   end

endmodule

// File: tb/tb_downstream_vc_receiver.sv
// Directed bench for downstream_vc_receiver (BUFFER_SIZE=8, OFF_MARGIN=2).
// Inputs change 1 time unit after a rising edge; outputs are checked at that
// same point, i.e. they reflect the edge just taken.

module tb_downstream_vc_receiver;
   import downstream_vc_receiver_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic overflow_err, proto_err;
   vc_state_t [VC_NUM-1:0] vc_state;

   int n_cmp  = 0;
   int n_fail = 0;

   downstream_vc_receiver_if bus ();

   downstream_vc_receiver #(.BUFFER_SIZE(8), .OFF_MARGIN(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .link           (bus.slave),
      .overflow_err_o (overflow_err),
      .proto_err_o    (proto_err),
      .vc_state_o     (vc_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_flit(input flit_label_t l, input int vc, input int pay);
      bus.data_i.flit_label = l;
      bus.data_i.vc_id      = VC_W'(vc);
      bus.data_i.payload    = PAYLOAD_W'(pay);
      bus.valid_flit_i      = 1'b1;
   endtask

   task automatic write(input flit_label_t l, input int vc, input int pay);
      set_flit(l, vc, pay);
      tick();
      bus.valid_flit_i = 1'b0;
   endtask

   task automatic pop(input int vc);
      bus.rd_en_i = 1'b1;
      bus.rd_vc_i = VC_W'(vc);
      tick();
      bus.rd_en_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic check_popped(input string tag, input flit_label_t l, input int pay);
      check({tag, "_valid"}, 32'(bus.flit_valid_o), 32'd1);
      check({tag, "_label"}, 32'(bus.flit_o.flit_label), 32'(l));
      check({tag, "_pay"},   32'(bus.flit_o.payload), 32'(pay));
   endtask

   initial begin
      bus.data_i       = '0;
      bus.valid_flit_i = 1'b0;
      bus.rd_en_i      = 1'b0;
      bus.rd_vc_i      = '0;

      // ---- 1: reset state, then HEAD/BODY/TAIL on VC0 ----
      do_reset();
      check("rst_on_off",  32'(bus.on_off_o),         32'h3);
      check("rst_alloc",   32'(bus.is_allocatable_o), 32'h3);
      check("rst_empty",   32'(bus.vc_empty_o),       32'h3);
      check("rst_fvalid",  32'(bus.flit_valid_o),     32'h0);
      check("rst_flit",    32'(bus.flit_o),           32'h0);
      check("rst_ovf",     32'(overflow_err),         32'h0);
      check("rst_proto",   32'(proto_err),            32'h0);

      write(HEAD, 0, 1);
      check("t1_alloc_head", 32'(bus.is_allocatable_o), 32'h2);
      check("t1_empty_head", 32'(bus.vc_empty_o),       32'h2);
      write(BODY, 0, 2);
      write(TAIL, 0, 3);
      check("t1_alloc_tail", 32'(bus.is_allocatable_o), 32'h2);
      check("t1_state_drain", 32'(vc_state[0]), 32'(VC_DRAIN));
      pop(0);
      check_popped("t1_pop1", HEAD, 1);
      check("t1_alloc_p1", 32'(bus.is_allocatable_o), 32'h2);
      pop(0);
      check_popped("t1_pop2", BODY, 2);
      check("t1_alloc_p2", 32'(bus.is_allocatable_o), 32'h2);
      pop(0);
      check_popped("t1_pop3", TAIL, 3);
      check("t1_alloc_p3", 32'(bus.is_allocatable_o), 32'h3);
      check("t1_empty_p3", 32'(bus.vc_empty_o),       32'h3);
      tick();
      check("t1_fvalid_idle", 32'(bus.flit_valid_o), 32'h0);

      // ---- 2: on/off flow control on VC1 ----
      do_reset();
      write(HEAD, 1, 10);
      for (int i = 1; i < 5; i++) write(BODY, 1, 10 + i);
      check("t2_on_off_5", 32'(bus.on_off_o), 32'h3);
      write(BODY, 1, 15);
      check("t2_on_off_6", 32'(bus.on_off_o), 32'h1);
      pop(1);
      check("t2_on_off_pop", 32'(bus.on_off_o), 32'h3);
      check_popped("t2_pop", HEAD, 10);

      // ---- 3: overflow on VC0 ----
      do_reset();
      write(HEAD, 0, 1);
      for (int i = 2; i <= 8; i++) write(BODY, 0, i);
      check("t3_ovf_8", 32'(overflow_err), 32'h0);
      check("t3_on_off_full", 32'(bus.on_off_o), 32'h2);
      write(BODY, 0, 9);
      check("t3_ovf_9", 32'(overflow_err), 32'h1);
      check("t3_proto_9", 32'(proto_err),  32'h0);
      pop(0);
      check_popped("t3_pop1", HEAD, 1);
      for (int i = 2; i <= 8; i++) begin
         pop(0);
         check_popped("t3_popn", BODY, i);
      end
      check("t3_empty", 32'(bus.vc_empty_o), 32'h3);
      check("t3_ovf_sticky", 32'(overflow_err), 32'h1);
      pop(0);
      check("t3_empty_pop", 32'(bus.flit_valid_o), 32'h0);
      check("t3_state", 32'(vc_state[0]), 32'(VC_ACTIVE));

      // ---- 3b: full VC written and popped in one cycle ----
      do_reset();
      write(HEAD, 0, 1);
      for (int i = 2; i <= 8; i++) write(BODY, 0, i);
      set_flit(BODY, 0, 9);
      pop(0);
      bus.valid_flit_i = 1'b0;
      check("t3b_ovf", 32'(overflow_err), 32'h0);
      check_popped("t3b_pop", HEAD, 1);
      for (int i = 2; i <= 9; i++) begin
         pop(0);
         check_popped("t3b_popn", BODY, i);
      end
      check("t3b_empty", 32'(bus.vc_empty_o), 32'h3);

      // ---- 4: protocol errors ----
      do_reset();
      write(HEAD, 1, 20);
      check("t4_proto_ok", 32'(proto_err), 32'h0);
      write(BODY, 0, 21);
      check("t4_proto_body", 32'(proto_err), 32'h1);
      check("t4_st0", 32'(vc_state[0]), 32'(VC_IDLE));
      check("t4_empty0", 32'(bus.vc_empty_o[0]), 32'h1);
      do_reset();
      write(HEAD, 1, 22);
      write(HEAD, 1, 23);
      check("t4_proto_head", 32'(proto_err), 32'h1);
      check("t4_st1", 32'(vc_state[1]), 32'(VC_ACTIVE));
      pop(1);
      check_popped("t4_pop", HEAD, 22);
      check("t4_empty1", 32'(bus.vc_empty_o[1]), 32'h1);
      do_reset();
      write(HEADTAIL, 0, 24);
      check("t4_st_drain", 32'(vc_state[0]), 32'(VC_DRAIN));
      write(HEAD, 0, 25);
      check("t4_proto_drain", 32'(proto_err), 32'h1);
      pop(0);
      check_popped("t4_pop_ht", HEADTAIL, 24);
      check("t4_idle_after", 32'(vc_state[0]), 32'(VC_IDLE));
      check("t4_ovf", 32'(overflow_err), 32'h0);

      // ---- 5: steady write+pop across pointer wrap ----
      do_reset();
      write(HEAD, 0, 100);
      write(BODY, 0, 101);
      write(BODY, 0, 102);
      for (int i = 0; i < 20; i++) begin
         set_flit(BODY, 0, 103 + i);
         pop(0);
         bus.valid_flit_i = 1'b0;
         check_popped("t5_pop", (i == 0) ? HEAD : BODY, 100 + i);
         check("t5_on_off", 32'(bus.on_off_o), 32'h3);
      end
      for (int i = 20; i < 23; i++) begin
         check("t5_nonempty", 32'(bus.vc_empty_o[0]), 32'h0);
         pop(0);
         check_popped("t5_tail", BODY, 100 + i);
      end
      check("t5_empty", 32'(bus.vc_empty_o), 32'h3);
      check("t5_ovf", 32'(overflow_err), 32'h0);

      // ---- 6: reset mid-packet ----
      do_reset();
      write(HEAD, 0, 30);
      for (int i = 1; i < 4; i++) write(BODY, 0, 30 + i);
      write(HEAD, 1, 40);
      bus.rd_en_i = 1'b1;
      bus.rd_vc_i = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.rd_en_i = 1'b0;
      check("t6_st0", 32'(vc_state[0]), 32'(VC_IDLE));
      check("t6_st1", 32'(vc_state[1]), 32'(VC_IDLE));
      check("t6_empty", 32'(bus.vc_empty_o), 32'h3);
      check("t6_on_off", 32'(bus.on_off_o), 32'h3);
      check("t6_alloc", 32'(bus.is_allocatable_o), 32'h3);
      check("t6_fvalid", 32'(bus.flit_valid_o), 32'h0);
      pop(0);
      check("t6_pop_empty", 32'(bus.flit_valid_o), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
